sync_fifo: RTL
==============

Name: sync_fifo

Overview:
Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering between pipeline stages.
- Depth, width and almost-full/almost-empty thresholds are configurable.
- Exposes an occupancy count and registered overflow/underflow error pulses.
- Supports two read modes, selected at build time: standard (registered read, 1-cycle latency) or first-word-fall-through (FWFT).

Parameters:
data_width, 8, bits per word
fifo_depth, 32, number of words; must be a power of 2 and >= 4
addr_width, log2(fifo_depth), memory address width (derived; not overridden)
fwft, 0, 0 = standard read mode; 1 = first-word-fall-through mode
almost_full_thresh, fifo_depth-4, almost_full asserts when count >= this value
almost_empty_thresh, 4, almost_empty asserts when count <= this value

Ports:
clk  input  1  single clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request
din  input  data_width  write data
rd_en  input  1  read request (standard mode) / read acknowledge (FWFT mode)
dout  output  data_width  read data, registered
full  output  1  count == fifo_depth
empty  output  1  no word available on the read side
almost_full  output  1  count >= almost_full_thresh
almost_empty  output  1  count <= almost_empty_thresh
count  output  addr_width+1  words held, 0..fifo_depth
overflow  output  1  1-cycle pulse: write was rejected
underflow  output  1  1-cycle pulse: read was rejected

Behaviour:
- Reset (rst high at an edge):
  - wr_ptr, rd_ptr and count go to 0; dout goes to 0; the FWFT output-valid flag is cleared.
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset overrides any simultaneous wr_en/rd_en; reset mid-stream discards all stored words.
- Pointers: addr_width+1 bits, binary, wrap modulo 2*fifo_depth; the low addr_width bits index memory.
- Write acceptance: wr_en && !full. An accepted write stores din at wr_ptr and increments wr_ptr.
- Rejected write (wr_en && full): state is unchanged; overflow=1 for exactly the following cycle.
- Read acceptance: rd_en && !empty. A rejected read (rd_en && empty) gives underflow=1 for the following cycle; state is unchanged.
- count:
  - +1 on accepted write only; -1 on accepted read only.
  - Unchanged when both are accepted in the same cycle or when neither is.
  - Never exceeds fifo_depth and never underflows.
- Flags full, almost_full and almost_empty are decoded from registered count; no combinational path from inputs.
- Standard mode (fwft=0):
  - empty = (count == 0).
  - An accepted read loads dout with mem[rd_ptr] at that edge (1-cycle latency) and increments rd_ptr.
  - dout holds its value when no read is accepted.
  - A write into an empty FIFO at edge k gives empty=0 after edge k; a read issued in the next cycle can be accepted.
- FWFT mode (fwft=1):
  - An internal output register with a valid flag sits after the memory. count includes the word in the output register.
  - empty = !valid; dout always shows the head word while valid=1.
  - The output register loads mem[rd_ptr] (and rd_ptr increments) when memory holds at least one word and (valid=0 or a read is accepted).
  - A read accepted with no refill available clears valid.
  - No bypass: a write into a completely empty FIFO at edge k gives count=1 after k but empty=1 until after edge k+1.
  - In FWFT mode, count=1 with empty=1 for one cycle is therefore legal.
- Simultaneous write and read:
  - When full: only the read is accepted; the write overflows.
  - When empty in standard mode: only the write is accepted; the read underflows.
- Total capacity is fifo_depth words in both modes.

Test Plan:
- Standard mode, depth 32: reset, then write 0x00..0x1F on consecutive cycles -> full=1 and count=32 after the 32nd write; almost_full first high at count=28. Then read 32 times -> dout sequence 0x00..0x1F, each one cycle after rd_en; empty=1 after the last read.
- Write while full (wr_en with din=0xAA) -> overflow pulses for 1 cycle; count stays 32; 0xAA is never read out. Read while empty -> underflow pulses for 1 cycle; dout unchanged.
- With count=10, assert wr_en and rd_en together for 20 cycles -> count stays 10; data order is preserved across pointer wrap-around past index 31.
- FWFT mode: write 0x5A into an empty FIFO at edge k -> count=1 after k; empty=0 and dout=0x5A after k+1 without any rd_en. Pulse rd_en -> empty=1 next cycle, count=0.
- FWFT mode: fill to full, then read back-to-back -> a new head word appears on dout every cycle with no bubbles; order is preserved.
- Assert rst with count=17 in the middle of a burst -> after the edge: count=0, empty=1, full=0, dout=0; a subsequent write/read returns only the new data.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, almost flags, error pulses
// and a build-time choice of registered (1-cycle) or first-word-fall-through read.
module sync_fifo #(
   parameter int data_width = 8,
   parameter int fifo_depth = 32,
   parameter int fwft = 0,
   parameter int almost_full_thresh = fifo_depth - 4,
   parameter int almost_empty_thresh = 4,
   localparam int addr_width = $clog2(fifo_depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [data_width-1:0] din,
   input  logic                  rd_en,
   output logic [data_width-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [addr_width:0]   count,
   output logic                  overflow,
   output logic                  underflow
);
   localparam logic [addr_width:0] c_depth = (addr_width+1)'(fifo_depth);
   localparam logic [addr_width:0] c_af = (addr_width+1)'(almost_full_thresh);
   localparam logic [addr_width:0] c_ae = (addr_width+1)'(almost_empty_thresh);

   logic [data_width-1:0] r_mem [fifo_depth];
   logic [addr_width:0]   r_wr_ptr, r_rd_ptr, r_count;
   logic [data_width-1:0] r_dout;
   logic                  r_valid, r_ovf, r_udf;
   logic                  w_full, w_empty, w_wr, w_rd, w_load;

   assign w_full  = r_count == c_depth;
   assign w_empty = (fwft != 0) ? !r_valid : r_count == 0;
   assign w_wr    = wr_en && !w_full;
   assign w_rd    = rd_en && !w_empty;
   // In FWFT the output register refills from memory whenever it is free or being consumed
   assign w_load  = (fwft != 0) ? (r_wr_ptr != r_rd_ptr) && (!r_valid || w_rd) : w_rd;

   always_ff @(posedge clk) begin
      if (w_wr && !rst) r_mem[r_wr_ptr[addr_width-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1;
         if (w_load) begin
            r_dout   <= r_mem[r_rd_ptr[addr_width-1:0]];
            r_rd_ptr <= r_rd_ptr + 1;
         end
         r_valid <= (fwft != 0) && (w_load || (r_valid && !w_rd));
         r_count <= (w_wr && !w_rd) ? r_count + 1 : (!w_wr && w_rd) ? r_count - 1 : r_count;
         r_ovf   <= wr_en && w_full;
         r_udf   <= rd_en && w_empty;
      end
   end

   assign dout         = r_dout;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = r_count >= c_af;
   assign almost_empty = r_count <= c_ae;
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;
endmodule
